// File: rtl/cpu_types_pkg.sv
// Shared types for the memory request path: RAM status encoding, word type and arbiter states.
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    DACC = 3'd1,
    IACC = 3'd2,
    RESP = 3'd3,
    ERR  = 3'd4
  } arb_state_t;

endpackage

// File: rtl/mem_request_arbiter_timer.sv
// Access watchdog: counts cycles while enabled, saturating at TIMEOUT-1 where expired is raised.
// Combinational expired flag; clear has priority over enable.
module access_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic core_clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] count;

  assign expired = (count == CW'(TIMEOUT - 1));

  always_ff @(posedge core_clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/mem_request_arbiter.sv
// Single-port RAM arbiter for fetch and data requests, data first; request to hit is 3 cycles minimum.
// Requesters hold their lines until ihit/dhit; RAM stalls via ramstate BUSY, bounded by a timeout.
module mem_request_arbiter
  import cpu_types_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              ihit,
  output logic              dhit,
  output logic [DATA_W-1:0] iload,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              mem_err
);

  arb_state_t state, state_n;
  ramstate_t  rs;

  logic              ramren_n, ramwen_n, ihit_n, dhit_n, err_n;
  logic [ADDR_W-1:0] ramaddr_n;
  logic [DATA_W-1:0] ramstore_n, iload_n, dload_n;
  logic              abort_q, abort_n, fetch_abort;
  logic              in_acc, expired;

  assign rs          = ramstate_t'(ramstate);
  assign in_acc      = (state == DACC) || (state == IACC);
  // A flushed fetch shows up as iREN dropping or the fetch address moving away from the one in flight.
  assign fetch_abort = abort_q || !iREN || (iaddr != ramaddr);

  access_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .core_clk (CLK),
    .rst      (RST),
    .clr      (!in_acc),
    .en       (in_acc),
    .expired  (expired)
  );

  always_comb begin
    state_n    = state;
    ramren_n   = ramREN;
    ramwen_n   = ramWEN;
    ramaddr_n  = ramaddr;
    ramstore_n = ramstore;
    ihit_n     = 1'b0;
    dhit_n     = 1'b0;
    iload_n    = iload;
    dload_n    = dload;
    err_n      = mem_err;
    abort_n    = abort_q;

    case (state)
      IDLE: begin
        abort_n = 1'b0;
        if (dREN || dWEN) begin
          state_n    = DACC;
          ramwen_n   = dWEN;
          ramren_n   = !dWEN;
          ramaddr_n  = daddr;
          ramstore_n = dstore;
        end else if (iREN) begin
          state_n   = IACC;
          ramren_n  = 1'b1;
          ramwen_n  = 1'b0;
          ramaddr_n = iaddr;
        end
      end

      DACC: begin
        if (rs == ERROR || (rs != ACCESS && expired)) begin
          state_n  = ERR;
          ramren_n = 1'b0;
          ramwen_n = 1'b0;
          err_n    = 1'b1;
        end else if (rs == ACCESS) begin
          if (ramREN) dload_n = ramload;
          dhit_n   = 1'b1;
          ramren_n = 1'b0;
          ramwen_n = 1'b0;
          state_n  = RESP;
        end
      end

      IACC: begin
        if (rs == ERROR || (rs != ACCESS && expired)) begin
          state_n  = ERR;
          ramren_n = 1'b0;
          ramwen_n = 1'b0;
          err_n    = 1'b1;
        end else if (rs == ACCESS) begin
          ramren_n = 1'b0;
          ramwen_n = 1'b0;
          if (fetch_abort) begin
            state_n = IDLE;
          end else begin
            iload_n = ramload;
            ihit_n  = 1'b1;
            state_n = RESP;
          end
        end else begin
          abort_n = fetch_abort;
        end
      end

      RESP: state_n = IDLE;

      ERR: begin
        ramren_n = 1'b0;
        ramwen_n = 1'b0;
        err_n    = 1'b1;
      end

      default: begin
        state_n  = IDLE;
        ramren_n = 1'b0;
        ramwen_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ramREN   <= 1'b0;
      ramWEN   <= 1'b0;
      ramaddr  <= '0;
      ramstore <= '0;
      ihit     <= 1'b0;
      dhit     <= 1'b0;
      iload    <= '0;
      dload    <= '0;
      mem_err  <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      ramREN   <= ramren_n;
      ramWEN   <= ramwen_n;
      ramaddr  <= ramaddr_n;
      ramstore <= ramstore_n;
      ihit     <= ihit_n;
      dhit     <= dhit_n;
      iload    <= iload_n;
      dload    <= dload_n;
      mem_err  <= err_n;
      abort_q  <= abort_n;
    end
  end

endmodule
